// File: rtl/dlx_dmem_arbiter.sv
// dlx_dmem_arbiter: shares the single-port data RAM between the DLX memory stage and a debug port,
// one captured access at a time, round-robin on ties.
module dlx_dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_WORDS * 4);
  state_t state, state_nx;
  // owner and last_grant: 1 = debug port, 0 = pipeline
  logic owner, last_grant, cap_we, cap_err;
  logic any_req, pick_dbg, sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_val;
  always_comb begin
    any_req   = cpu_req | dbg_req;
    pick_dbg  = dbg_req & (~cpu_req | ~last_grant);
    sel_we    = pick_dbg ? dbg_we : cpu_we;
    sel_addr  = pick_dbg ? dbg_addr : cpu_addr;
    sel_wdata = pick_dbg ? dbg_wdata : cpu_wdata;
    sel_err   = (sel_addr >= LIMIT) || (sel_addr[1:0] != 2'b00);
    rd_val    = (cap_we | cap_err) ? '0 : ram_rdata;
    state_nx  = state == IDLE ? (any_req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  end
  assign cpu_stall = cpu_req & ~cpu_ack;
  // ram_addr/ram_wdata double as the captured request so the RAM never sees live inputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cap_we     <= 1'b0;
      cap_err    <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      dbg_err    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (any_req) begin
          owner     <= pick_dbg;
          cap_we    <= sel_we;
          cap_err   <= sel_err;
          ram_addr  <= sel_addr;
          ram_wdata <= sel_wdata;
          ram_we    <= sel_we & ~sel_err;
        end
        ACCESS: begin
          ram_we <= 1'b0;
          if (owner) begin
            dbg_rdata <= rd_val;
            dbg_ack   <= 1'b1;
            dbg_err   <= cap_err;
          end else begin
            cpu_rdata <= rd_val;
            cpu_ack   <= 1'b1;
            cpu_err   <= cap_err;
          end
        end
        RESP: begin
          cpu_ack    <= 1'b0;
          dbg_ack    <= 1'b0;
          cpu_err    <= 1'b0;
          dbg_err    <= 1'b0;
          last_grant <= owner;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dlx_dmem_arbiter.sv
// tb_dlx_dmem_arbiter: randomized and directed checks of the RAM arbiter against a
// word-level memory model and a round-robin grant model.
module tb_dlx_dmem_arbiter;
  logic clock = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata, ram_rdata;
  logic cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err, ram_we;
  logic [31:0] mem [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64];
  logic [31:0] we_addr_seen = '0;
  logic [31:0] exp_crd, exp_drd;
  logic model_last;
  int total = 0, bad = 0, we_cnt = 0;

  always #5 clock = ~clock;

  dlx_dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM_BLOCK stand-in: combinational read, write on the clock edge
  assign ram_rdata = (ram_addr < 32'd256) ? mem[ram_addr[7:2]] : 32'hBAD0_BAD0;
  always @(posedge clock) if (ram_we && ram_addr < 32'd256) mem[ram_addr[7:2]] <= ram_wdata;
  always @(negedge clock) if (ram_we) begin we_cnt++; we_addr_seen = ram_addr; end

  task automatic model_apply(input logic we, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic er);
    er = (a >= 32'd256) || (a[1:0] != 2'b00);
    if (!er && we) ref_mem[a[7:2]] = d;
    rd = (er || we) ? 32'h0 : ref_mem[a[7:2]];
  endtask

  task automatic model_reset();
    model_last = 1'b1;
    exp_crd = '0;
    exp_drd = '0;
  endtask

  task automatic access(input logic port, input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    if (port) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    lat = -1;
    rd = 'x;
    er = 'x;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (port ? dbg_ack : cpu_ack) begin
        lat = i;
        rd = port ? dbg_rdata : cpu_rdata;
        er = port ? dbg_err : cpu_err;
        break;
      end
    end
    if (port) dbg_req = 0; else cpu_req = 0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, w0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'h1E;
    repeat (3) @(negedge clock);
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    total++; if ({cpu_ack, dbg_ack} !== 2'b00) begin bad++; $display("FAIL rst_acks: got %b want 00", {cpu_ack, dbg_ack}); end
    total++; if ({cpu_rdata, dbg_rdata, ram_addr} !== 96'h0) begin bad++; $display("FAIL rst_regs: got %h want 0", {cpu_rdata, dbg_rdata, ram_addr}); end
    cpu_req = 0;
    reset = 1;
    model_reset();
    @(negedge clock);
    w0 = we_cnt;
    access(0, 1, 32'h8, 32'h1E, rd, er, lat);
    model_apply(1, 32'h8, 32'h1E, mrd, mer);
    exp_crd = mrd;
    model_last = 0;
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
    total++; if (er !== mer) begin bad++; $display("FAIL wr_err: got %b want %b", er, mer); end
    total++; if (we_cnt - w0 !== 1 || we_addr_seen !== 32'h8) begin bad++; $display("FAIL wr_we_pulse: got %0d@%h want 1@8", we_cnt - w0, we_addr_seen); end
    total++; if (mem[2] !== 32'h1E) begin bad++; $display("FAIL wr_ram2: got %h want 1e", mem[2]); end
  endtask

  task automatic test_readback();
    logic [31:0] mrd;
    logic mer;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
    #1;
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL stall_req: got %b want 1", cpu_stall); end
    @(negedge clock);
    total++; if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin bad++; $display("FAIL stall_access: got %b/%b want 1/0", cpu_stall, cpu_ack); end
    @(negedge clock);
    model_apply(0, 32'h8, 0, mrd, mer);
    exp_crd = mrd;
    model_last = 0;
    total++; if (cpu_ack !== 1'b1 || cpu_stall !== 1'b0) begin bad++; $display("FAIL rd_ack_stall: got %b/%b want 1/0", cpu_ack, cpu_stall); end
    total++; if (cpu_rdata !== mrd || cpu_err !== mer) begin bad++; $display("FAIL rd_data: got %h/%b want %h/%b", cpu_rdata, cpu_err, mrd, mer); end
    cpu_req = 0;
    @(negedge clock);
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_width: got %b want 0", cpu_ack); end
  endtask

  task automatic test_contention();
    logic [31:0] mrd, rd;
    logic mer, p, exp_p;
    int last_i;
    reset = 0;
    @(negedge clock);
    reset = 1;
    model_reset();
    @(negedge clock);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h4; cpu_wdata = 32'hA;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h4; dbg_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      last_i = -1;
      for (int i = 1; i <= 6; i++) begin
        @(negedge clock);
        if (cpu_ack || dbg_ack) begin last_i = i; break; end
      end
      p = dbg_ack;
      exp_p = ~model_last;
      total++; if (last_i !== (k == 0 ? 2 : 3) || (cpu_ack && dbg_ack) || p !== exp_p) begin
        bad++; $display("FAIL tie_grant%0d: got port %b after %0d want port %b after %0d", k, p, last_i, exp_p, k == 0 ? 2 : 3);
      end
      model_apply(p ? 1'b0 : 1'b1, 32'h4, p ? 32'h0 : 32'hA, mrd, mer);
      rd = p ? dbg_rdata : cpu_rdata;
      total++; if (rd !== mrd) begin bad++; $display("FAIL tie_data%0d: got %h want %h", k, rd, mrd); end
      if (p) exp_drd = mrd; else exp_crd = mrd;
      model_last = p;
    end
    cpu_req = 0;
    dbg_req = 0;
    @(negedge clock);
  endtask

  task automatic test_range();
    logic [31:0] rd, m0;
    logic er;
    int lat, w0;
    w0 = we_cnt;
    m0 = mem[0];
    access(1, 1, 32'h100, 32'h77, rd, er, lat);
    exp_drd = 32'h0;
    model_last = 1;
    total++; if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL range_dbg_wr: got %0d/%b/%h want 2/1/0", lat, er, rd); end
    total++; if (we_cnt !== w0 || mem[0] !== m0) begin bad++; $display("FAIL range_no_we: got %0d writes want 0", we_cnt - w0); end
    access(0, 0, 32'h6, 32'h0, rd, er, lat);
    exp_crd = 32'h0;
    model_last = 0;
    total++; if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL range_cpu_misalign: got %0d/%b/%h want 2/1/0", lat, er, rd); end
    access(1, 1, 32'hFC, 32'hCAFE, rd, er, lat);
    model_apply(1, 32'hFC, 32'hCAFE, exp_drd, er);
    model_last = 1;
    total++; if (er !== 1'b0 || mem[63] !== 32'hCAFE || we_cnt - w0 !== 1) begin bad++; $display("FAIL range_top_word: got %b/%h want 0/cafe", er, mem[63]); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, acks;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'hC; cpu_wdata = 32'h55;
    @(posedge clock);
    #2;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL mid_we_before: got %b want 1", ram_we); end
    reset = 0;
    #1;
    total++; if (ram_we !== 1'b0 || cpu_ack !== 1'b0) begin bad++; $display("FAIL mid_we_async: got %b/%b want 0/0", ram_we, cpu_ack); end
    cpu_req = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    model_reset();
    acks = 0;
    repeat (3) begin @(negedge clock); acks += int'(cpu_ack) + int'(dbg_ack); end
    total++; if (acks !== 0 || mem[3] !== ref_mem[3]) begin bad++; $display("FAIL mid_no_commit: got %0d acks ram3=%h want 0 acks ram3=%h", acks, mem[3], ref_mem[3]); end
    access(0, 0, 32'hC, 32'h0, rd, er, lat);
    model_apply(0, 32'hC, 0, mrd, mer);
    exp_crd = mrd;
    model_last = 0;
    total++; if (lat !== 2 || rd !== mrd) begin bad++; $display("FAIL mid_after_idle: got %0d/%h want 2/%h", lat, rd, mrd); end
  endtask

  task automatic test_held_change();
    logic [31:0] mrd, m8;
    logic mer;
    m8 = mem[8];
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h10; dbg_wdata = 32'h1234;
    @(negedge clock);
    dbg_addr = 32'h20; dbg_wdata = 32'h9999; dbg_we = 0;
    #1;
    total++; if (ram_addr !== 32'h10 || ram_wdata !== 32'h1234 || ram_we !== 1'b1) begin
      bad++; $display("FAIL held_ram_bus: got %h/%h/%b want 10/1234/1", ram_addr, ram_wdata, ram_we);
    end
    @(negedge clock);
    total++; if (dbg_ack !== 1'b1 || dbg_err !== 1'b0) begin bad++; $display("FAIL held_ack: got %b/%b want 1/0", dbg_ack, dbg_err); end
    dbg_req = 0;
    @(negedge clock);
    model_apply(1, 32'h10, 32'h1234, mrd, mer);
    exp_drd = mrd;
    model_last = 1;
    total++; if (mem[4] !== 32'h1234 || mem[8] !== m8) begin bad++; $display("FAIL held_ram: got %h/%h want 1234/%h", mem[4], mem[8], m8); end
  endtask

  function automatic logic [31:0] gen_addr();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    a = 32'($urandom_range(0, 63)) << 2;
    if (r == 0) a = a + 32'd256 + (32'($urandom_range(0, 15)) << 8);
    if (r == 1) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int mode, w0, nw, order;
      logic c_on, d_on, cw, dw, got_c, got_d, p, exp_p, mer, we;
      logic [31:0] ca, cd, da, dd, mrd, a, d, rd, er_o, other, other_exp;
      mode = $urandom_range(0, 2);
      c_on = mode != 1;
      d_on = mode != 0;
      cw = 1'($urandom_range(0, 1)); ca = gen_addr(); cd = $urandom;
      dw = 1'($urandom_range(0, 1)); da = gen_addr(); dd = $urandom;
      w0 = we_cnt; nw = 0; order = 0;
      cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; cpu_req = c_on;
      dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_req = d_on;
      got_c = !c_on;
      got_d = !d_on;
      for (int i = 1; i <= 12 && !(got_c && got_d); i++) begin
        @(negedge clock);
        if (cpu_ack && dbg_ack) begin
          total++; bad++; $display("FAIL rnd_double_ack it%0d: got both acks want one", it);
        end else if (cpu_ack || dbg_ack) begin
          p = dbg_ack;
          exp_p = (!got_c && !got_d) ? !model_last : got_c;
          total++; if (p !== exp_p || i !== 2 + 3 * order) begin
            bad++; $display("FAIL rnd_grant it%0d: got port %b at %0d want port %b at %0d", it, p, i, exp_p, 2 + 3 * order);
          end
          we = p ? dw : cw; a = p ? da : ca; d = p ? dd : cd;
          model_apply(we, a, d, mrd, mer);
          if (we && !mer) nw++;
          rd = p ? dbg_rdata : cpu_rdata;
          er_o = {31'h0, p ? dbg_err : cpu_err};
          other = p ? cpu_rdata : dbg_rdata;
          other_exp = p ? exp_crd : exp_drd;
          total++; if (rd !== mrd || er_o[0] !== mer || other !== other_exp) begin
            bad++; $display("FAIL rnd_resp it%0d: got %h/%b other %h want %h/%b other %h", it, rd, er_o[0], other, mrd, mer, other_exp);
          end
          if (p) begin exp_drd = mrd; got_d = 1; dbg_req = 0; end
          else begin exp_crd = mrd; got_c = 1; cpu_req = 0; end
          model_last = p;
          order++;
        end
      end
      cpu_req = 0;
      dbg_req = 0;
      total++; if (!(got_c && got_d)) begin bad++; $display("FAIL rnd_timeout it%0d: got acks %b%b want 11", it, got_c, got_d); end
      @(negedge clock);
      total++; if (we_cnt - w0 !== nw) begin bad++; $display("FAIL rnd_we_count it%0d: got %0d want %0d", it, we_cnt - w0, nw); end
    end
    begin
      int diffs;
      diffs = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
      total++; if (diffs !== 0) begin bad++; $display("FAIL rnd_ram_image: got %0d differing words want 0", diffs); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    model_reset();
    @(negedge clock);
    test_reset();
    test_readback();
    test_contention();
    test_range();
    test_reset_mid_write();
    test_held_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
